// File: rtl/mm_engine.sv
// mm_engine: runtime-sized A*B matrix multiply with scaled, saturated results and a valid-tracked MAC pipeline
module mm_engine #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 9,
  parameter int RES_depth_bits = 9,
  parameter int DIM_BITS       = 8,
  parameter int RD_LAT         = 1,
  parameter int ACC_W          = 32
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      Start,
  input  logic [DIM_BITS-1:0]       cfg_m,
  input  logic [DIM_BITS-1:0]       cfg_n,
  input  logic [DIM_BITS-1:0]       cfg_p,
  input  logic [$clog2(ACC_W)-1:0]  cfg_shift,
  output logic                      Busy,
  output logic                      Done,
  output logic                      A_read_en,
  output logic [A_depth_bits-1:0]   A_read_address,
  input  logic [width-1:0]          A_read_data_out,
  output logic                      B_read_en,
  output logic [B_depth_bits-1:0]   B_read_address,
  input  logic [width-1:0]          B_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_depth_bits-1:0] RES_write_address,
  output logic [width-1:0]          RES_write_data_in
);
  localparam int SW = $clog2(ACC_W);
  localparam int AW = 2 * DIM_BITS;
  localparam logic [DIM_BITS-1:0] ONE = 1;
  if (ACC_W < 2 * width + DIM_BITS) begin : g_acc_chk
    $error("ACC_W must be at least 2*width+DIM_BITS");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
    $error("RD_LAT must be 1..4");
  end
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, STORE, DONE} state_t;
  state_t state_q, state_d;
  logic [DIM_BITS-1:0] m_q, m_d, n_q, n_d, p_q, p_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [2:0] d_q, d_d;
  logic [RD_LAT-1:0] v_q, v_d;
  logic [ACC_W-1:0] acc_q, acc_d, scaled;
  logic we_q, we_d;
  logic [RES_depth_bits-1:0] wa_q, wa_d;
  logic [width-1:0] wd_q, wd_d;
  logic [AW-1:0] a_full, b_full, r_full;
  logic issue;
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    n_d = n_q;
    p_d = p_q;
    sh_d = sh_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    d_d = d_q;
    issue = state_q == RUN;
    v_d = RD_LAT'({v_q, issue});
    acc_d = v_q[RD_LAT-1] ? acc_q + ACC_W'(A_read_data_out) * ACC_W'(B_read_data_out) : acc_q;
    case (state_q)
      IDLE: if (Start) begin
        m_d = cfg_m;
        n_d = cfg_n;
        p_d = cfg_p;
        sh_d = cfg_shift;
        i_d = '0;
        j_d = '0;
        k_d = '0;
        acc_d = '0;
        state_d = (cfg_m != '0 && cfg_n != '0 && cfg_p != '0) ? RUN : DONE;
      end
      RUN: begin
        j_d = (j_q == n_q - ONE) ? '0 : j_q + ONE;
        d_d = '0;
        state_d = (j_q == n_q - ONE) ? DRAIN : RUN;
      end
      DRAIN: begin
        d_d = d_q + 3'd1;
        state_d = (d_q == 3'(RD_LAT - 1)) ? STORE : DRAIN;
      end
      STORE: begin
        acc_d = '0;
        k_d = (k_q == p_q - ONE) ? '0 : k_q + ONE;
        i_d = (k_q == p_q - ONE) ? i_q + ONE : i_q;
        state_d = (k_q == p_q - ONE && i_q == m_q - ONE) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
    a_full = AW'(i_q) * AW'(n_q) + AW'(j_q);
    b_full = AW'(j_q) * AW'(p_q) + AW'(k_q);
    r_full = AW'(i_q) * AW'(p_q) + AW'(k_q);
    scaled = acc_d >> sh_q;
    we_d = state_d == STORE;
    wa_d = we_d ? RES_depth_bits'(r_full) : wa_q;
    wd_d = we_d ? ((|scaled[ACC_W-1:width]) ? '1 : scaled[width-1:0]) : wd_q;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      m_q <= '0;
      n_q <= '0;
      p_q <= '0;
      sh_q <= '0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      d_q <= '0;
      v_q <= '0;
      acc_q <= '0;
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      n_q <= n_d;
      p_q <= p_d;
      sh_q <= sh_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      d_q <= d_d;
      v_q <= v_d;
      acc_q <= acc_d;
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end
  assign Busy = state_q == RUN || state_q == DRAIN || state_q == STORE;
  assign Done = state_q == DONE;
  assign A_read_en = issue;
  assign B_read_en = issue;
  assign A_read_address = A_depth_bits'(a_full);
  assign B_read_address = B_depth_bits'(b_full);
  assign RES_write_en = we_q;
  assign RES_write_address = wa_q;
  assign RES_write_data_in = wd_q;
endmodule

// File: tb/tb_mm_engine.sv
// tb_mm_engine: scoreboard bench running RD_LAT=1 and RD_LAT=3 engines side by side
module tb_mm_engine;
  logic clk = 1'b0, aresetn = 1'b0, start = 1'b0;
  logic [7:0] cfg_m = '0, cfg_n = '0, cfg_p = '0;
  logic [4:0] cfg_shift = '0;
  logic busy[2], done[2], a_en[2], b_en[2], we[2];
  logic [8:0] a_addr[2], b_addr[2], w_addr[2];
  logic [7:0] a_rd[2], b_rd[2], w_data[2];
  logic [7:0] a_mem[512], b_mem[512];
  logic [7:0] ap[2][4], bp[2][4];
  int exp_q[2][$];
  int tests = 0, failed = 0, cyc = 0, acc_cyc = 0;
  int d_cyc[2], busy_n[2], done_n[2], rd_n[2], wr_n[2];
  int e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mm_engine #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .aresetn(aresetn), .Start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
    .cfg_shift(cfg_shift), .Busy(busy[0]), .Done(done[0]),
    .A_read_en(a_en[0]), .A_read_address(a_addr[0]), .A_read_data_out(a_rd[0]),
    .B_read_en(b_en[0]), .B_read_address(b_addr[0]), .B_read_data_out(b_rd[0]),
    .RES_write_en(we[0]), .RES_write_address(w_addr[0]), .RES_write_data_in(w_data[0])
  );
  mm_engine #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .aresetn(aresetn), .Start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
    .cfg_shift(cfg_shift), .Busy(busy[1]), .Done(done[1]),
    .A_read_en(a_en[1]), .A_read_address(a_addr[1]), .A_read_data_out(a_rd[1]),
    .B_read_en(b_en[1]), .B_read_address(b_addr[1]), .B_read_data_out(b_rd[1]),
    .RES_write_en(we[1]), .RES_write_address(w_addr[1]), .RES_write_data_in(w_data[1])
  );
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      ap[g][0] <= a_en[g] ? a_mem[a_addr[g]] : 8'd0;
      bp[g][0] <= b_en[g] ? b_mem[b_addr[g]] : 8'd0;
      for (int s = 1; s < 4; s++) begin
        ap[g][s] <= ap[g][s-1];
        bp[g][s] <= bp[g][s-1];
      end
    end
  end
  assign a_rd[0] = ap[0][0];
  assign b_rd[0] = bp[0][0];
  assign a_rd[1] = ap[1][2];
  assign b_rd[1] = bp[1][2];
  task automatic check(string tag, longint got, longint exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (busy[g]) busy_n[g]++;
      if (a_en[g]) rd_n[g]++;
      if (done[g]) begin
        done_n[g]++;
        if (d_cyc[g] < 0) d_cyc[g] = cyc - acc_cyc + 1;
      end
      if (we[g]) begin
        wr_n[g]++;
        if (exp_q[g].size() == 0) check($sformatf("wr%0d_extra", g), 1, 0);
        else begin
          e = exp_q[g].pop_front();
          check($sformatf("wr%0d_addr", g), w_addr[g], e >> 8);
          check($sformatf("wr%0d_data", g), w_data[g], e & 255);
        end
      end
    end
  end
  task automatic push_exp(int m, int n, int p, int sh);
    longint s;
    int v;
    for (int i = 0; i < m; i++)
      for (int k = 0; k < p; k++) begin
        s = 0;
        for (int j = 0; j < n; j++) s += longint'(a_mem[i*n+j]) * longint'(b_mem[j*p+k]);
        s = s >> sh;
        v = (s > 255) ? 255 : int'(s);
        for (int g = 0; g < 2; g++) exp_q[g].push_back((i*p+k)*256 + v);
      end
  endtask
  task automatic launch(int m, int n, int p, int sh);
    for (int g = 0; g < 2; g++) begin
      d_cyc[g] = -1; busy_n[g] = 0; done_n[g] = 0; rd_n[g] = 0; wr_n[g] = 0;
    end
    cfg_m = 8'(m); cfg_n = 8'(n); cfg_p = 8'(p); cfg_shift = 5'(sh);
    start = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
    start = 1'b0;
  endtask
  task automatic run_job(string name, int m, int n, int p, int sh, bit disturb);
    int tot;
    push_exp(m, n, p, sh);
    launch(m, n, p, sh);
    for (int t = 0; t < 2000 && (d_cyc[0] < 0 || d_cyc[1] < 0); t++) begin
      @(posedge clk);
      #1;
      if (disturb && t == 3) begin start = 1'b1; cfg_n = 8'(n + 3); end
      if (disturb && t == 4) start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      tot = m * p * (n + (g == 0 ? 1 : 3) + 1);
      check($sformatf("%s_l%0d_done_cyc", name, g), d_cyc[g], tot + 1);
      check($sformatf("%s_l%0d_busy_cyc", name, g), busy_n[g], tot);
      check($sformatf("%s_l%0d_done_cnt", name, g), done_n[g], 1);
      check($sformatf("%s_l%0d_reads", name, g), rd_n[g], m * p * n);
      check($sformatf("%s_l%0d_writes", name, g), wr_n[g], m * p);
      check($sformatf("%s_l%0d_left", name, g), exp_q[g].size(), 0);
    end
  endtask
  task automatic check_zero(string name);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_l%0d_ctl", name, g), {busy[g], done[g], a_en[g], b_en[g], we[g]}, 0);
      check($sformatf("%s_l%0d_bus", name, g), {a_addr[g], b_addr[g], w_addr[g], w_data[g]}, 0);
    end
  endtask
  task automatic load_2x2();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
  endtask
  initial begin
    for (int x = 0; x < 512; x++) begin a_mem[x] = 0; b_mem[x] = 0; end
    for (int g = 0; g < 2; g++) begin
      d_cyc[g] = -1; busy_n[g] = 0; done_n[g] = 0; rd_n[g] = 0; wr_n[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    load_2x2();
    run_job("mm2", 2, 2, 2, 0, 1'b0);
    run_job("mm2_sh2", 2, 2, 2, 2, 1'b0);
    for (int x = 0; x < 8; x++) begin a_mem[x] = 255; b_mem[x] = 255; end
    run_job("sat8", 1, 8, 1, 8, 1'b0);
    run_job("sat12", 1, 8, 1, 12, 1'b0);
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
    for (int x = 0; x < 4; x++) b_mem[x] = 1;
    run_job("col", 3, 1, 4, 0, 1'b0);
    load_2x2();
    run_job("disturb", 2, 2, 2, 0, 1'b1);
    run_job("zero_p", 2, 2, 0, 0, 1'b0);
    push_exp(2, 2, 2, 0);
    launch(2, 2, 2, 0);
    repeat (4) @(posedge clk);
    #1 aresetn = 1'b0;
    #1 check_zero("abort");
    for (int g = 0; g < 2; g++) begin exp_q[g].delete(); done_n[g] = 0; end
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check($sformatf("abort_l%0d_no_done", g), done_n[g], 0);
    run_job("after_abort", 2, 2, 2, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mm_engine.md
Name: mm_engine

Overview:
- Generalised successor of the team's fixed-size matrix-multiply controller.
- Computes RES[M×P] = (A[M×N] · B[N×P]) >> shift, with M, N and P set at runtime.
- Scaled results saturate to the output width.
- Sits between the A/B input BRAMs and the RES output BRAM in the coprocessor datapath.
- Synchronous-read memories with parametrised read latency are supported via a valid-tracked MAC pipeline.
- Start/Busy/Done handshake to the AXI-side controller.

Parameters:
- width, 8, bits per element of A, B and RES (unsigned)
- A_depth_bits, 9, A memory address width
- B_depth_bits, 9, B memory address width
- RES_depth_bits, 9, RES memory address width
- DIM_BITS, 8, width of each runtime dimension input (max dimension 2^DIM_BITS-1)
- RD_LAT, 1, cycles from read address/enable to valid read data (1..4)
- ACC_W, 32, accumulator width; must be ≥ 2*width + DIM_BITS (elaboration error otherwise)

Ports:
- clk  in  1  clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- Start  in  1  start request, level-sampled in IDLE
- cfg_m  in  DIM_BITS  rows of A and RES
- cfg_n  in  DIM_BITS  inner dimension
- cfg_p  in  DIM_BITS  columns of B and RES
- cfg_shift  in  $clog2(ACC_W)  right-shift applied to each accumulated sum
- Busy  out  1  high while a job is in progress
- Done  out  1  one-cycle completion pulse
- A_read_en  out  1  A read enable
- A_read_address  out  A_depth_bits  A address, row-major i*N+j
- A_read_data_out  in  width  A read data
- B_read_en  out  1  B read enable
- B_read_address  out  B_depth_bits  B address, row-major j*P+k
- B_read_data_out  in  width  B read data
- RES_write_en  out  1  RES write strobe
- RES_write_address  out  RES_depth_bits  RES address, i*P+k
- RES_write_data_in  out  width  scaled, saturated result

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE; all outputs 0; counters, accumulator and valid pipe cleared. Asserting reset mid-job aborts the job: no further writes and no Done.
- States:
  - IDLE → RUN on Start=1 when all dims are nonzero. On that edge, latch cfg_* and set Busy=1. cfg changes after this edge are ignored.
  - IDLE → DONE on Start=1 when any dim is 0. No memory access occurs.
  - RUN: one read issue per cycle for j=0..N-1. Both read enables are 1 and addresses are computed from the latched dims. Truncate addresses to the port widths; keeping dims within memory depth is the caller's responsibility. After the j=N-1 issue, go to DRAIN.
  - DRAIN: RD_LAT cycles with read enables 0, so outstanding data can land, then go to STORE.
  - STORE: one cycle with RES_write_en=1, address i*P+k, and data = sat(acc >> cfg_shift). Clear acc and advance k, then i (k wraps to 0). Go to RUN, or to DONE after element (M-1, P-1).
  - DONE: Done=1 and Busy=0 for one cycle, then IDLE. Start held high re-launches from IDLE on the following cycle.
- MAC:
  - A valid shift register of length RD_LAT tags each issue.
  - When the tagged data arrives, acc += A_read_data_out*B_read_data_out, computed as a full 2*width product zero-extended to ACC_W.
  - No data is lost across the RUN→DRAIN boundary.
- Saturation: if (acc >> cfg_shift) ≥ 2^width, output 2^width-1; otherwise output the low width bits.
- Latency:
  - Each element takes N+RD_LAT+1 cycles.
  - The first RUN cycle is the cycle after Start is accepted.
  - Done is asserted M*P*(N+RD_LAT+1)+1 cycles after the Start-accept edge.
- Read enables are 0 outside RUN. RES_write_en is 0 outside STORE. RES_write_address/data hold their values after STORE.
- Start while Busy=1 is ignored, with no effect on the running job.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], M=N=P=2, shift=0, RD_LAT=1 → writes RES[0..3]=19,22,43,50 in that order; Done on cycle 17 after accept; Busy high for cycles 1..16.
- Same matrices, shift=2, RD_LAT=3 → RES=4,5,10,12; each element takes 6 cycles; Done 25 cycles after accept; verify no product is dropped or double-counted.
- M=1, N=8, P=1, all A=B=255, shift=8 → acc=520200, shifted 2032 → RES[0]=255 (saturated); then with shift=12 → RES[0]=127.
- M=3, N=1, P=4, A=[1,2,3], B=[1,1,1,1], shift=0 → RES[0..11]=1,1,1,1,2,2,2,2,3,3,3,3; confirm address order i*P+k.
- Pulse Start at cycle 5 of a running job, and change cfg_n mid-job → results identical to an undisturbed run; a single Done pulse.
- cfg_p=0 with Start → no read/write strobes, Done 1 cycle after accept. Separately, drop aresetn mid-RUN → all outputs 0 immediately, no Done; a fresh Start after release completes correctly.
